// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter slice.
// Holds the datapath width, the Arith opcode encoding, the arbiter FSM
// state type and a helper giving the execute time of each opcode.
package alu_req_arbiter_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ALU_OP_ADD = 3'd0,
        ALU_OP_SUB = 3'd1,
        ALU_OP_INC = 3'd2,
        ALU_OP_DEC = 3'd3,
        ALU_OP_SHL = 3'd4,
        ALU_OP_SHR = 3'd5,
        ALU_OP_MUL = 3'd6,
        ALU_OP_DIV = 3'd7
    } enum_alu_opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } enum_arb_state_t;

    // Number of EXEC cycles the operands must be held on the Arith unit.
    function automatic int op_latency(enum_alu_opcode_t op, int multi_cycles);
        case (op)
            ALU_OP_MUL, ALU_OP_DIV: return multi_cycles;
            default:                return 1;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester-side bus of the ALU request arbiter.
// Ports (per requester unless noted):
//   req_valid/req_ready  request handshake, req_a/req_b/req_carry/req_op operands
//   resp_valid/resp_ready response handshake
//   resp_data/resp_flag/resp_err shared result bus (valid for the resp_valid bit)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high for the same requester. req_ready is one-hot and may rise
// only while the arbiter is idle; resp_valid is one-hot and, once high, stays
// high with stable resp_data/resp_flag/resp_err until resp_ready of that
// requester is seen high on an edge.
interface alu_req_arbiter_if
    import alu_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]                 req_carry;
    enum_alu_opcode_t [NUM_REQ-1:0]     req_op;
    logic [NUM_REQ-1:0]                 resp_valid;
    logic [NUM_REQ-1:0]                 resp_ready;
    logic [DATA_WIDTH-1:0]              resp_data;
    logic [1:0]                         resp_flag;
    logic                               resp_err;

    modport master (
        output req_valid, req_a, req_b, req_carry, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_flag, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_carry, req_op, resp_ready,
        output req_ready, resp_valid, resp_data, resp_flag, resp_err
    );
endinterface

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Combinational round-robin grant selection.
// Ports:
//   req         request vector
//   ptr         highest-priority requester index
//   grant       one-hot grant (zero when no request)
//   grant_idx   index of the granted requester
//   grant_valid any request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);
    int k;

    // Scan offsets from farthest to nearest so the requester closest to
    // ptr (searching upward with wrap) is the last one written and wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        k           = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (req[k]) begin
                grant_idx   = IDX_W'(k);
                grant_valid = 1'b1;
            end
        end
        grant = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational Arith unit between NUM_REQ requesters.
// Each operation is accepted (round-robin), executed with operands held on
// the Arith inputs for the opcode's latency, then returned registered to the
// winning requester. DIV by zero is answered with resp_err without ever
// reaching the Arith unit.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus                   requester interface (slave side)
//   alu_in_a/alu_in_b/alu_carry/alu_opcode  to Arith
//   alu_out/alu_flag      from Arith
//   busy                  FSM not idle
//   state_dbg             current FSM state
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MULTI_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_req_arbiter_if.slave      bus,
    output logic [DATA_WIDTH-1:0] alu_in_a,
    output logic [DATA_WIDTH-1:0] alu_in_b,
    output logic                  alu_carry,
    output enum_alu_opcode_t      alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [1:0]            alu_flag,
    output logic                  busy,
    output enum_arb_state_t       state_dbg
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MULTI_CYCLES > 1) ? $clog2(MULTI_CYCLES) : 1;

    enum_arb_state_t       state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      owner;
    logic [CNT_W-1:0]      exec_cnt;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [1:0]            resp_flag_q;
    logic                  resp_err_q;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  div_zero;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req         (bus.req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign div_zero = (bus.req_op[grant_idx] == ALU_OP_DIV) && (bus.req_b[grant_idx] == '0);

    // Accept strobe is forced low during reset so no requester sees a phantom grant.
    assign bus.req_ready  = (rst_n && state == IDLE) ? grant : '0;
    assign bus.resp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_flag  = resp_flag_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = (state != IDLE);
    assign state_dbg      = state;

    // The alu_* registers double as the operand latch: they load only at an
    // accept that goes to EXEC, so they stay stable through EXEC and keep
    // their last value otherwise (a trapped divide leaves them untouched).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            exec_cnt    <= '0;
            resp_data_q <= '0;
            resp_flag_q <= '0;
            resp_err_q  <= 1'b0;
            alu_in_a    <= '0;
            alu_in_b    <= '0;
            alu_carry   <= 1'b0;
            alu_opcode  <= ALU_OP_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_idx;
                        if (div_zero) begin
                            resp_data_q <= '0;
                            resp_flag_q <= '0;
                            resp_err_q  <= 1'b1;
                            state       <= RESP;
                        end else begin
                            alu_in_a   <= bus.req_a[grant_idx];
                            alu_in_b   <= bus.req_b[grant_idx];
                            alu_carry  <= bus.req_carry[grant_idx];
                            alu_opcode <= bus.req_op[grant_idx];
                            exec_cnt   <= CNT_W'(op_latency(bus.req_op[grant_idx], MULTI_CYCLES) - 1);
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (exec_cnt == '0) begin
                        resp_data_q <= alu_out;
                        resp_flag_q <= alu_flag;
                        resp_err_q  <= 1'b0;
                        state       <= RESP;
                    end else begin
                        exec_cnt <= exec_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready[owner]) begin
                        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
    import alu_req_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int MC = 2;
    localparam int DW = DATA_WIDTH;
    localparam int W  = 14;   // {owner[2:0], err, flag[1:0], data[7:0]}

    logic             clk;
    logic             rst_n;
    logic [DW-1:0]    alu_in_a;
    logic [DW-1:0]    alu_in_b;
    logic             alu_carry;
    enum_alu_opcode_t alu_opcode;
    logic [DW-1:0]    alu_out;
    logic [1:0]       alu_flag;
    logic             busy;
    enum_arb_state_t  state_dbg;

    alu_req_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_req_arbiter #(.NUM_REQ(N), .MULTI_CYCLES(MC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_in_a   (alu_in_a),
        .alu_in_b   (alu_in_b),
        .alu_carry  (alu_carry),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_flag   (alu_flag),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Arith model: flags = {carry/borrow, zero} ----------------
    function automatic logic [DW+1:0] arith(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic c, input enum_alu_opcode_t op);
        logic [DW:0]     r;
        logic [2*DW-1:0] p;
        logic [DW-1:0]   d;
        logic            co;
        r = '0; p = '0; d = '0; co = 1'b0;
        case (op)
            ALU_OP_ADD: begin r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c}; d = r[DW-1:0]; co = r[DW]; end
            ALU_OP_SUB: begin r = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, c}; d = r[DW-1:0]; co = r[DW]; end
            ALU_OP_INC: begin r = {1'b0, a} + (DW+1)'(1); d = r[DW-1:0]; co = r[DW]; end
            ALU_OP_DEC: begin r = {1'b0, a} - (DW+1)'(1); d = r[DW-1:0]; co = r[DW]; end
            ALU_OP_SHL: begin d = {a[DW-2:0], c}; co = a[DW-1]; end
            ALU_OP_SHR: begin d = {c, a[DW-1:1]}; co = a[0]; end
            ALU_OP_MUL: begin p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b}; d = p[DW-1:0]; co = |p[2*DW-1:DW]; end
            default:    begin if (b != '0) d = a / b; else begin d = '1; co = 1'b1; end end
        endcase
        return {co, (d == '0), d};
    endfunction

    always_comb {alu_flag, alu_out} = arith(alu_in_a, alu_in_b, alu_carry, alu_opcode);

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [W-1:0]  exp_q[$];
    int            exp_cyc_q[$];
    logic [W-1:0]  exp_for_req [N];
    int            lat_for_req [N];
    logic [19:0]   alu_for_req [N];
    logic [19:0]   cur_alu;
    logic [N-1:0]  prev_resp_valid;
    int            grant_idx_log[$];
    int            grant_cyc_log[$];

    typedef struct {
        int               idx;
        enum_alu_opcode_t op;
        logic [7:0]       a;
        logic [7:0]       b;
        logic             c;
        logic [7:0]       d;
        logic [1:0]       f;
        logic             e;
        int               lat;  // edges from accept edge to resp_valid visible
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pushes on accept, checks alu hold in EXEC, compares every
    // response cycle against the queue head and pops on handshake.
    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (rst_n) begin
            if (bus.req_ready != '0) begin
                check("grant_onehot", $countones(bus.req_ready), 1);
                for (int i = 0; i < N; i++) begin
                    if (bus.req_ready[i]) begin
                        exp_q.push_back(exp_for_req[i]);
                        exp_cyc_q.push_back(cyc + lat_for_req[i]);
                        grant_idx_log.push_back(i);
                        grant_cyc_log.push_back(cyc);
                        if (!exp_for_req[i][10]) cur_alu = alu_for_req[i];
                    end
                end
            end
            if (busy && bus.resp_valid == '0)
                check("alu_hold", {alu_in_a, alu_in_b, alu_carry, alu_opcode}, cur_alu);
            if (bus.resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", bus.resp_valid, 0);
                end else begin
                    e = exp_q[0];
                    if (prev_resp_valid == '0) check("resp_latency", cyc, exp_cyc_q[0]);
                    check("resp_valid", bus.resp_valid, N'(1) << e[13:11]);
                    check("resp_data", bus.resp_data, e[7:0]);
                    check("resp_flag", bus.resp_flag, e[9:8]);
                    check("resp_err", bus.resp_err, e[10]);
                    if ((bus.resp_valid & bus.resp_ready) != '0) begin
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                    end
                end
            end
            prev_resp_valid = bus.resp_valid;
        end else begin
            prev_resp_valid = '0;
        end
    end

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic set_req(input int idx, input enum_alu_opcode_t op, input logic [7:0] a,
                           input logic [7:0] b, input logic c, input logic [7:0] d,
                           input logic [1:0] f, input logic e, input int lat);
        bus.req_op[idx]    = op;
        bus.req_a[idx]     = a;
        bus.req_b[idx]     = b;
        bus.req_carry[idx] = c;
        exp_for_req[idx]   = {3'(idx), e, f, d};
        lat_for_req[idx]   = lat;
        alu_for_req[idx]   = {a, b, c, op};
    endtask

    task automatic wait_grant(input int idx, input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready[idx] && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, "_grant_seen"}, bus.req_ready[idx], 1);
    endtask

    // Drop valid right after the accept edge and scramble the operands.
    task automatic drop_req(input int idx);
        @(posedge clk);
        #1;
        bus.req_valid[idx] = 1'b0;
        bus.req_a[idx]     = 8'($urandom_range(0, 255));
        bus.req_b[idx]     = 8'($urandom_range(1, 255));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        enum_alu_opcode_t prev_op;
        int n;

        vecs[0]  = '{0, ALU_OP_ADD, 8'h0F, 8'h01, 1'b1, 8'h11, 2'b00, 1'b0, 2};
        vecs[1]  = '{1, ALU_OP_SUB, 8'h20, 8'h05, 1'b0, 8'h1B, 2'b00, 1'b0, 2};
        vecs[2]  = '{2, ALU_OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 2'b11, 1'b0, 3};
        vecs[3]  = '{1, ALU_OP_DIV, 8'h37, 8'h00, 1'b0, 8'h00, 2'b00, 1'b1, 1};
        vecs[4]  = '{3, ALU_OP_DIV, 8'h64, 8'h07, 1'b0, 8'h0E, 2'b00, 1'b0, 3};
        vecs[5]  = '{0, ALU_OP_SHL, 8'h81, 8'h00, 1'b1, 8'h03, 2'b10, 1'b0, 2};
        vecs[6]  = '{2, ALU_OP_SHR, 8'h01, 8'h00, 1'b0, 8'h00, 2'b11, 1'b0, 2};
        vecs[7]  = '{3, ALU_OP_INC, 8'hFF, 8'h00, 1'b0, 8'h00, 2'b11, 1'b0, 2};
        vecs[8]  = '{1, ALU_OP_DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 2'b10, 1'b0, 2};
        vecs[9]  = '{0, ALU_OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 2'b01, 1'b0, 2};
        vecs[10] = '{2, ALU_OP_ADD, 8'hF0, 8'h20, 1'b0, 8'h10, 2'b10, 1'b0, 2};

        rst_n          = 1'b0;
        bus.req_valid  = '1;   // req_ready must stay low while in reset
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_carry  = '0;
        for (int i = 0; i < N; i++) bus.req_op[i] = ALU_OP_ADD;
        bus.resp_ready = '1;
        cur_alu        = '0;
        prev_resp_valid = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_bus", {bus.resp_data, bus.resp_flag, bus.resp_err}, 0);
        check("rst_alu_in", {alu_in_a, alu_in_b, alu_carry}, 0);
        check("rst_alu_opcode", alu_opcode, ALU_OP_ADD);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, IDLE);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;

        // Table-driven single operations
        for (int v = 0; v < 11; v++) begin
            @(posedge clk);
            #1;
            set_req(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].c,
                    vecs[v].d, vecs[v].f, vecs[v].e, vecs[v].lat);
            prev_op = alu_opcode;
            bus.req_valid[vecs[v].idx] = 1'b1;
            wait_grant(vecs[v].idx, "vec");
            drop_req(vecs[v].idx);
            drain("vec");
            if (vecs[v].e) check("div0_alu_opcode_unchanged", alu_opcode, prev_op);
        end

        // Backpressure: req3 held in RESP while req0 waits
        @(posedge clk);
        #1;
        bus.resp_ready = 4'b0111;
        set_req(3, ALU_OP_SUB, 8'h50, 8'h10, 1'b1, 8'h3F, 2'b00, 1'b0, 2);
        bus.req_valid[3] = 1'b1;
        wait_grant(3, "bp3");
        drop_req(3);
        set_req(0, ALU_OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 2'b00, 1'b0, 2);
        bus.req_valid[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid[3] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp3_seen", bus.resp_valid[3], 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_no_grant", bus.req_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.resp_ready[3] = 1'b1;
        @(negedge clk);
        check("bp_no_grant_before_edge", bus.req_ready, 0);
        @(negedge clk);
        check("bp_grant0_after_release", bus.req_ready, 4'b0001);
        drop_req(0);
        drain("bp");

        // Round-robin fairness from reset
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            set_req(i, ALU_OP_ADD, 8'(i), 8'h10, 1'b0, 8'(8'h10 + i), 2'b00, 1'b0, 2);
        grant_idx_log.delete();
        grant_cyc_log.delete();
        bus.resp_ready = '1;
        bus.req_valid  = '1;
        n = 0;
        while (grant_idx_log.size() < 5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("rr_grant_count", grant_idx_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_idx_log.size(); i++) begin
            check("rr_order", grant_idx_log[i], i % N);
            if (i > 0) check("rr_interval", grant_cyc_log[i] - grant_cyc_log[i-1], 3);
        end
        drain("rr");

        // Reset during a MUL in EXEC
        @(posedge clk);
        #1;
        set_req(2, ALU_OP_MUL, 8'h03, 8'h05, 1'b0, 8'h0F, 2'b00, 1'b0, 3);
        set_req(0, ALU_OP_ADD, 8'h07, 8'h01, 1'b0, 8'h08, 2'b00, 1'b0, 2);
        bus.req_valid[2] = 1'b1;
        wait_grant(2, "rst_mul");
        @(posedge clk);
        #3;
        bus.req_valid = 4'b1011;
        check("mid_exec_state", state_dbg, EXEC);
        rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req_ready", bus.req_ready, 0);
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_alu", {alu_in_a, alu_in_b, alu_carry, alu_opcode}, {8'h00, 8'h00, 1'b0, ALU_OP_ADD});
        check("mid_rst_resp_bus", {bus.resp_data, bus.resp_flag, bus.resp_err}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_rst_no_resp", bus.resp_valid, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant0", bus.req_ready, 4'b0001);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational Arith unit between NUM_REQ requesters (e.g. integer pipe, address-gen, debug port).
- Each operation runs as accept, then execute, then respond:
  - a round-robin grant accepts one request;
  - operands are held stable on the ALU for the opcode's execute time;
  - the registered result is returned to the winning requester.
- MUL/DIV get a multicycle execute window for timing closure. Divide-by-zero is trapped before it reaches the ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MULTI_CYCLES, 2, execute cycles for ALU_OP_MUL/ALU_OP_DIV (>=1).
- DATA_WIDTH: taken from CPU_package (8 in default build), not a module parameter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_a  in  NUM_REQ x DATA_WIDTH  operand A per requester
- req_b  in  NUM_REQ x DATA_WIDTH  operand B per requester
- req_carry  in  NUM_REQ  carry/shift-in bit per requester
- req_op  in  NUM_REQ x enum_alu_opcode_t  opcode per requester
- resp_valid  out  NUM_REQ  one-hot response valid
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_data  out  DATA_WIDTH  result
- resp_flag  out  2  ALU flag bits
- resp_err  out  1  divide-by-zero
- alu_in_a  out  DATA_WIDTH  to Arith in_a
- alu_in_b  out  DATA_WIDTH  to Arith in_b
- alu_carry  out  1  to Arith input_carry
- alu_opcode  out  enum_alu_opcode_t  to Arith alu_opcode
- alu_out  in  DATA_WIDTH  from Arith arith_out
- alu_flag  in  2  from Arith arith_out_flag
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr_ptr = 0;
  - req_ready = 0 (forced while rst_n low), resp_valid = 0;
  - resp_data / resp_flag / resp_err = 0;
  - alu_in_a / alu_in_b / alu_carry = 0, alu_opcode = ALU_OP_ADD;
  - busy = 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first requester with req_valid set, searching upward from rr_ptr with wrap-around.
  - req_ready[g] is combinational, high only in IDLE, one-hot.
  - On that clock edge: latch a/b/carry/op of g and owner = g.
  - DIV with b==0: go to RESP directly with resp_data = 0, resp_flag = 0, resp_err = 1.
  - Otherwise go to EXEC with exec_cnt = latency - 1.
  - Latency: 1 for ADD/SUB/INC/DEC/SHL/SHR; MULTI_CYCLES for MUL/DIV.
  - No valid request: stay in IDLE.
- EXEC:
  - alu_* driven from the latched registers, held stable for every EXEC cycle.
  - exec_cnt decrements each cycle.
  - On the cycle where exec_cnt == 0: capture alu_out into resp_data, alu_flag into resp_flag, resp_err = 0; go to RESP.
- RESP:
  - resp_valid[owner] = 1, other bits 0.
  - resp_data / resp_flag / resp_err held stable until resp_ready[owner].
  - resp_ready from non-owners is ignored.
  - On handshake: rr_ptr = (owner + 1) mod NUM_REQ, go to IDLE.
- alu_* outputs hold their last values outside EXEC (no toggling for power).
- Latency: single-cycle op accepted at edge 0 gives resp_valid high after edge 2. MUL/DIV give resp_valid after edge 1 + MULTI_CYCLES.
- Minimum issue interval is 3 cycles with no back-to-back overlap; accept is never concurrent with RESP.
- Requester rules:
  - A requester may drop req_valid before it is granted.
  - Operands are sampled only at the accept edge; later changes have no effect on the result.
- Width: result/flags come verbatim from Arith; the arbiter does no arithmetic beyond the b==0 compare and the counter.
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded with no response, and rr_ptr returns to 0.

Decomposition:
- CPU_package already holds DATA_WIDTH and enum_alu_opcode_t. Add to it:
  - typedef enum_arb_state_t {IDLE, EXEC, RESP};
  - function op_latency(opcode, MULTI_CYCLES).
- Sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: request vector, rr_ptr;
  - output: one-hot grant plus index, purely combinational.
- Arith stays outside, instantiated beside this block at the datapath level.

Test Plan:
- Single ADD:
  - Stimulus: req0 a=8'h0F, b=8'h01, carry=1, ADD.
  - Response: req_ready[0] in cycle 0; resp_valid=4'b0001 at cycle 2 with resp_data=8'h11, resp_flag=0, resp_err=0.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high with resp_ready tied 1.
  - Response: grants in order 0,1,2,3,0; each new grant 3 cycles after the previous.
- MUL latency (MULTI_CYCLES=2):
  - Stimulus: req2 MUL a=8'h10, b=8'h10.
  - Response: alu_* stable for 2 EXEC cycles; resp_valid[2] after edge 3; data/flags match Arith model.
- Divide-by-zero:
  - Stimulus: req1 DIV b=0.
  - Response: Arith never sees DIV (alu_opcode unchanged); resp_valid[1] after edge 1 with resp_err=1, resp_data=0.
- Backpressure:
  - Stimulus: resp_ready[3]=0 for 5 cycles during req3 SUB while req0 is valid.
  - Response: response held stable; req0 not granted until the cycle after resp_ready[3] rises.
- Reset during EXEC:
  - Stimulus: rst_n low mid-MUL.
  - Response: all outputs return to reset values immediately, no resp_valid; after release the next grant goes to requester 0.
